// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
// Holds the FSM state, Booth digit encoding and iteration-count function.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_t;

    function automatic int n_iter(input int dw);
        return dw / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product generator, purely combinational.
// Maps a 3-bit multiplier window onto 0, +-X or +-2X in OWIDTH+2 bits.
module booth_r4_enc
    import mul_pkg::*;
#(
    parameter int DWIDTH = 4
) (
    input  logic [2:0]          code,
    input  logic [DWIDTH+1:0]   x_ext,
    output logic [2*DWIDTH+1:0] pp
);

    localparam int EW = DWIDTH + 2;
    localparam int PW = 2 * DWIDTH + 2;

    booth_t      digit;
    logic [PW-1:0] x1;
    logic [PW-1:0] x2;

    assign x1 = {{(PW - EW){x_ext[EW-1]}}, x_ext};
    assign x2 = x1 << 1;

    always_comb begin
        digit = BD_ZERO;
        unique case (code)
            3'b001, 3'b010: digit = BD_P1;
            3'b011:         digit = BD_P2;
            3'b100:         digit = BD_M2;
            3'b101, 3'b110: digit = BD_M1;
            default:        digit = BD_ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        unique case (digit)
            BD_P1:   pp = x1;
            BD_P2:   pp = x2;
            BD_M1:   pp = -x1;
            BD_M2:   pp = -x2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/r4_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per CALC cycle.
// Signed operand support is compiled in with `define R4_MUL_SIGNED_EN.
module r4_booth_seq_mul
    import mul_pkg::*;
#(
    parameter int DWIDTH = 4,
    parameter int OWIDTH = 2 * DWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] Xin,
    input  logic [DWIDTH-1:0] Yin,
    input  logic              i_signed,
    input  logic              i_valid,
    output logic              i_ready,
    output logic [OWIDTH-1:0] Zout,
    output logic              o_valid
);

    localparam int N  = n_iter(DWIDTH);
    localparam int EW = DWIDTH + 2;
    localparam int PW = OWIDTH + 2;
    localparam int CW = $clog2(N + 1);

`ifdef R4_MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_nxt;
    logic [PW-1:0] pp;
    logic [EW-1:0] x_ext;
    logic [EW:0]   y_sh;
    logic          sgn;
    logic          accept;

    assign sgn    = i_signed & SIGNED_EN;
    assign accept = i_valid & i_ready;

    booth_r4_enc #(
        .DWIDTH(DWIDTH)
    ) u_enc (
        .code (y_sh[2:0]),
        .x_ext(x_ext),
        .pp   (pp)
    );

    // Digit i carries weight 4^i, so shift by twice the step index.
    assign acc_nxt = acc + (pp << {cnt, 1'b0});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            x_ext   <= '0;
            y_sh    <= '0;
            Zout    <= '0;
            o_valid <= 1'b0;
            i_ready <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        x_ext   <= {{2{sgn & Xin[DWIDTH-1]}}, Xin};
                        y_sh    <= {{2{sgn & Yin[DWIDTH-1]}}, Yin, 1'b0};
                        acc     <= '0;
                        cnt     <= '0;
                        i_ready <= 1'b0;
                        state   <= CALC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    acc  <= acc_nxt;
                    y_sh <= y_sh >> 2;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        Zout    <= acc_nxt[OWIDTH-1:0];
                        o_valid <= 1'b1;
                        i_ready <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/r4_booth_seq_mul.md
R4_BOOTH_SEQ_MUL -- requirements
Module: r4_booth_seq_mul

Interface
REQ-001 Parameters SHALL be:
- DWIDTH, default 4: operand width; even, >= 4.
- OWIDTH, default 2*DWIDTH: product width; not overridden.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- Xin  in  DWIDTH  multiplicand.
- Yin  in  DWIDTH  multiplier.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_valid  in  1  operands valid.
- i_ready  out  1  block can accept an operation this cycle.
- Zout  out  OWIDTH  product; held until the next result.
- o_valid  out  1  one-cycle pulse, Zout newly valid.

Function
REQ-003 An accept SHALL occur on a rising edge where i_valid=1 and i_ready=1; Xin, Yin and i_signed are captured at that edge.
REQ-004 i_valid while i_ready=0 SHALL be ignored: no capture, no effect on the operation in flight.
REQ-005 Captured operands SHALL be extended to DWIDTH+2 bits: sign-extended if i_signed=1, zero-extended if 0.
REQ-006 Iteration count SHALL be N = DWIDTH/2 + 1, which yields 3 for DWIDTH=4.
REQ-007 The FSM SHALL have three states: IDLE, CALC and DONE.
- IDLE -> CALC on accept.
- CALC stays for exactly N cycles, then -> DONE.
- DONE -> CALC on accept, else -> IDLE.
REQ-008 Each CALC cycle SHALL perform one radix-4 Booth step.
- Digit from multiplier bits {y[2i+1], y[2i], y[2i-1]}, with y[-1]=0.
- Digit maps to {0, +X, +X, +2X, -2X, -X, -X, 0} for codes 000..111.
- Partial product added to the accumulator at weight 4^i; arithmetic is signed in OWIDTH+2 bits.
REQ-009 i_ready SHALL be 1 in IDLE and DONE and 0 in CALC, so back-to-back operations lose no cycle.
REQ-010 On the edge that enters DONE, Zout SHALL load the low OWIDTH bits of the accumulator, and o_valid SHALL be 1 for exactly that DONE cycle.
- Latency: o_valid is high in the cycle after the (N+1)-th rising edge counted from the accept edge.
REQ-011 Zout SHALL equal (Xin*Yin) mod 2^OWIDTH, interpreted per i_signed, for all operand values including the most-negative ones.
REQ-012 Zout SHALL hold its value through IDLE and through the next CALC, changing only on entry to DONE.

Reset
REQ-013 While rstn=0, outputs SHALL be: state IDLE, Zout=0, o_valid=0, i_ready=1, accumulator and iteration counter 0.
REQ-014 Inputs SHALL be ignored while rstn=0.
REQ-015 Reset asserted mid-CALC SHALL abort the operation; no o_valid is produced for it after release.
REQ-016 The first accept SHALL be possible on the first rising edge after rstn deasserts.

Configuration
REQ-017 Macro R4_MUL_SIGNED_EN SHALL control signed support.
- Defined: i_signed is honoured per REQ-005.
- Undefined: the i_signed port remains, but its value is ignored and all operands are treated as unsigned.

Structure
REQ-018 Shared package mul_pkg SHALL hold:
- the FSM state enum typedef;
- the Booth digit enum typedef;
- a constant function returning N from DWIDTH.
REQ-019 Sub-module booth_r4_enc SHALL be combinational: 3-bit code plus extended multiplicand in, signed partial product out.
- Instantiated once; the main module holds FSM, counter, shift register and accumulator.

Verification (DWIDTH=4)
REQ-020 After reset, accept Xin=2, Yin=3, i_signed=0 -> Zout=0x06, o_valid a single pulse 4 rising edges after accept, i_ready low for exactly 3 cycles.
REQ-021 Unsigned Xin=0xF, Yin=0xF -> 0xE1; with macro defined, signed Xin=0x8 (-8), Yin=0x7 -> 0xC8; signed 0x8*0x8 -> 0x40.
REQ-022 Xin=0xF, Yin=0x1, i_signed=1 -> 0xFF with macro defined, 0x0F without.
REQ-023 i_valid pulsed with Xin=5, Yin=5 during CALC of 2*3 -> result 0x06 only, single o_valid; accept in DONE of 3*3 followed by 4*4 -> 0x09 then 0x10 with no idle cycle between.
REQ-024 rstn dropped during the second CALC cycle -> Zout=0, o_valid=0, i_ready=1; no stale o_valid afterwards; next operation 7*7 -> 0x31.
